loa_adder_pipe: RTL and testbench

// - Parametrised, pipelined Lower-part OR Adder (LOA): the low k bits are approximated by

---
 rtl/loa_pkg.sv | 51 +++++
 rtl/loa_adder_pipe_or_vec.sv | 28 ++
 rtl/loa_adder_pipe.sv | 152 +++++++++++++++
 tb/tb_loa_adder_pipe.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/loa_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : loa_pkg
//  Purpose  : Shared defaults and helpers for the Lower-part OR Adder (LOA).
//             - LOA_WIDTH / LOA_MAX_APPROX : default operand width and max k
//             - clamp_k(k, max_k)          : min(k, max_k)
//             - loa_ref(a, b, k, w)        : bit-serial reference, returns
//                                            {cout, sum} for a w-bit LOA
//  Revision : 1.0  initial release
// ============================================================================
package loa_pkg;

  localparam int LOA_WIDTH      = 16;
  localparam int LOA_MAX_APPROX = 8;
  // Widest operand the reference function can model.
  localparam int LOA_MAXW       = 64;

  function automatic int unsigned clamp_k(input int unsigned k, input int unsigned max_k);
    return (k > max_k) ? max_k : k;
  endfunction

  // Reference LOA: bits below k are a|b, bits from k upward are a ripple
  // add seeded with a[k-1]&b[k-1]. Result bit w holds the carry out.
  // k must not exceed w.
  function automatic logic [LOA_MAXW:0] loa_ref(input logic [LOA_MAXW-1:0] a,
                                                input logic [LOA_MAXW-1:0] b,
                                                input int unsigned k,
                                                input int unsigned w);
    logic [LOA_MAXW:0]   r;
    logic [LOA_MAXW-1:0] ab;
    logic                c;
    r  = '0;
    ab = a & b;
    c  = (k == 0) ? 1'b0 : ab[6'(k - 1)];
    for (int i = 0; i < LOA_MAXW; i++) begin
      if (i < int'(w)) begin
        if (i < int'(k)) begin
          r[i[6:0]] = a[i[5:0]] | b[i[5:0]];
        end else begin
          r[i[6:0]] = a[i[5:0]] ^ b[i[5:0]] ^ c;
          c         = (a[i[5:0]] & b[i[5:0]]) | (c & (a[i[5:0]] ^ b[i[5:0]]));
        end
      end
    end
    r[7'(w)] = c;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/loa_adder_pipe_or_vec.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : or_vec
//  Purpose  : Masked bitwise OR, out[i] = en[i] ? a[i]|b[i] : 0. Vector form
//             of the single-bit OR cell used for the approximated low part.
//  Ports    : a, b  [WIDTH] operands
//             en    [WIDTH] per-bit enable (low-part mask)
//             out   [WIDTH] masked OR result
//  Revision : 1.0  initial release
// ============================================================================
module or_vec
  import loa_pkg::*;
#(
  parameter int WIDTH = LOA_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] en,
  output logic [WIDTH-1:0] out
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign out[i] = en[i] & (a[i] | b[i]);
  end

endmodule
`default_nettype wire

// File: rtl/loa_adder_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : loa_adder_pipe
//  Purpose  : Two-stage pipelined Lower-part OR Adder with per-beat k and
//             valid/ready streaming on both sides.
//  Ports    : clk, rst (async, active high)
//             in_valid/in_ready, a, b [WIDTH], approx_k [KW]  - input beat
//             out_valid/out_ready, sum [WIDTH], cout, k_used [KW] - result
//             approx_cnt [16] - saturating count of delivered beats with k>0
//  Revision : 1.0  initial release
// ============================================================================
module loa_adder_pipe
  import loa_pkg::*;
#(
  parameter  int WIDTH      = LOA_WIDTH,
  parameter  int MAX_APPROX = LOA_MAX_APPROX,
  localparam int KW         = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [KW-1:0]    approx_k,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic [KW-1:0]    k_used,
  output logic [15:0]      approx_cnt
);

  // Stage 1 state
  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_a_q,     s1_a_d;
  logic [WIDTH-1:0] s1_b_q,     s1_b_d;
  logic [KW-1:0]    s1_keff_q,  s1_keff_d;
  logic [WIDTH-1:0] s1_low_q,   s1_low_d;
  logic             s1_cin_q,   s1_cin_d;
  // Stage 2 state (the output register)
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] sum_q,      sum_d;
  logic             cout_q,     cout_d;
  logic [KW-1:0]    k_used_q,   k_used_d;
  logic [15:0]      cnt_q,      cnt_d;

  logic             s1_load;
  logic             s2_load;
  logic [KW-1:0]    keff_in;
  logic [WIDTH-1:0] mask_in;
  logic [WIDTH-1:0] low_in;
  logic [WIDTH-1:0] mask_s2;
  logic [WIDTH:0]   cin_vec;
  logic [WIDTH:0]   upper;

  or_vec #(.WIDTH(WIDTH)) u_or_vec (
    .a   (a),
    .b   (b),
    .en  (mask_in),
    .out (low_in)
  );

  always_comb begin
    s2_load  = !s2_valid_q || out_ready;
    s1_load  = !s1_valid_q || s2_load;
    in_ready = s1_load;

    keff_in  = KW'(clamp_k(32'(approx_k), MAX_APPROX));
    // Low-part mask: keff ones from bit 0; keff==WIDTH shifts all ones out.
    mask_in  = ~({WIDTH{1'b1}} << keff_in);

    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_keff_d  = s1_keff_q;
    s1_low_d   = s1_low_q;
    s1_cin_d   = s1_cin_q;
    if (s1_load) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_a_d    = a;
        s1_b_d    = b;
        s1_keff_d = keff_in;
        s1_low_d  = low_in;
        // Top bit of the mask selects a[keff-1]&b[keff-1]; empty mask -> 0.
        s1_cin_d  = |(a & b & mask_in & ~(mask_in >> 1));
      end
    end

    // Upper part: one add of the masked operands with cin injected at bit
    // keff. With keff==WIDTH the cin lands directly in the carry-out bit.
    mask_s2 = ~({WIDTH{1'b1}} << s1_keff_q);
    cin_vec = {{WIDTH{1'b0}}, s1_cin_q} << s1_keff_q;
    upper   = {1'b0, s1_a_q & ~mask_s2} + {1'b0, s1_b_q & ~mask_s2} + cin_vec;

    s2_valid_d = s2_valid_q;
    sum_d      = sum_q;
    cout_d     = cout_q;
    k_used_d   = k_used_q;
    if (s2_load) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        sum_d    = upper[WIDTH-1:0] | s1_low_q;
        cout_d   = upper[WIDTH];
        k_used_d = s1_keff_q;
      end
    end

    cnt_d = cnt_q;
    if (s2_valid_q && out_ready && (k_used_q != '0) && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_keff_q  <= '0;
      s1_low_q   <= '0;
      s1_cin_q   <= 1'b0;
      s2_valid_q <= 1'b0;
      sum_q      <= '0;
      cout_q     <= 1'b0;
      k_used_q   <= '0;
      cnt_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_keff_q  <= s1_keff_d;
      s1_low_q   <= s1_low_d;
      s1_cin_q   <= s1_cin_d;
      s2_valid_q <= s2_valid_d;
      sum_q      <= sum_d;
      cout_q     <= cout_d;
      k_used_q   <= k_used_d;
      cnt_q      <= cnt_d;
    end
  end

  assign out_valid  = s2_valid_q;
  assign sum        = sum_q;
  assign cout       = cout_q;
  assign k_used     = k_used_q;
  assign approx_cnt = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_loa_adder_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_loa_adder_pipe
//  Purpose  : Self-checking bench for loa_adder_pipe (WIDTH=8). Two DUTs share
//             the input stream: one with MAX_APPROX=8, one with MAX_APPROX=3.
//  Revision : 1.0  initial release
// ============================================================================
module tb_loa_adder_pipe;
  import loa_pkg::*;

  localparam int W  = 8;
  localparam int KW = $clog2(W + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, out_ready;
  logic [W-1:0]  a, b;
  logic [KW-1:0] k;

  logic          in_ready,  out_valid,  cout;
  logic [W-1:0]  sum;
  logic [KW-1:0] k_used;
  logic [15:0]   cnt;
  logic          in_ready_c, out_valid_c, cout_c;
  logic [W-1:0]  sum_c;
  logic [KW-1:0] k_used_c;
  logic [15:0]   cnt_c;

  loa_adder_pipe #(.WIDTH(W), .MAX_APPROX(8)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .approx_k(k), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .k_used(k_used), .approx_cnt(cnt)
  );

  loa_adder_pipe #(.WIDTH(W), .MAX_APPROX(3)) u_dut_c (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_c),
    .a(a), .b(b), .approx_k(k), .out_valid(out_valid_c), .out_ready(out_ready),
    .sum(sum_c), .cout(cout_c), .k_used(k_used_c), .approx_cnt(cnt_c)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int acc_total = 0;
  bit rnd_ready = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: plain integer arithmetic on the LOA definition.
  typedef struct packed {
    logic [KW-1:0] k;
    logic          c;
    logic [W-1:0]  s;
  } exp_t;

  function automatic exp_t model(input int av, input int bv, input int kr, input int maxk);
    exp_t e;
    int   kk, cin, s;
    kk  = (kr > maxk) ? maxk : kr;
    cin = (kk == 0) ? 0 : (((av >> (kk - 1)) & (bv >> (kk - 1))) & 1);
    s   = ((((av >> kk) + (bv >> kk) + cin) << kk) | ((av | bv) & ((1 << kk) - 1)));
    e.s = s[W-1:0];
    e.c = s[W];
    e.k = kk[KW-1:0];
    return e;
  endfunction

  exp_t q[$];
  exp_t qc[$];
  int   exp_cnt = 0;
  int   exp_cnt_c = 0;

  // Compare process: outputs and inputs are sampled mid-cycle; the handshakes
  // seen here take effect at the following rising edge.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      qc.delete();
      exp_cnt   = 0;
      exp_cnt_c = 0;
    end else begin
      chk("approx_cnt", cnt, exp_cnt);
      chk("approx_cnt_c", cnt_c, exp_cnt_c);
      if (out_valid) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL spurious_out: out_valid=1 with nothing in flight (t=%0t)", $time);
        end else begin
          chk("sum", sum, q[0].s);
          chk("cout", cout, q[0].c);
          chk("k_used", k_used, q[0].k);
          if (out_ready) begin
            if (q[0].k != 0 && exp_cnt < 65535) exp_cnt++;
            void'(q.pop_front());
          end
        end
      end
      if (out_valid_c) begin
        if (qc.size() == 0) begin
          checks++; errors++;
          $display("FAIL spurious_out_c: out_valid=1 with nothing in flight (t=%0t)", $time);
        end else begin
          chk("sum_c", sum_c, qc[0].s);
          chk("cout_c", cout_c, qc[0].c);
          chk("k_used_c", k_used_c, qc[0].k);
          if (out_ready) begin
            if (qc[0].k != 0 && exp_cnt_c < 65535) exp_cnt_c++;
            void'(qc.pop_front());
          end
        end
      end
      if (in_valid && in_ready)   q.push_back(model(int'(a), int'(b), int'(k), 8));
      if (in_valid && in_ready_c) qc.push_back(model(int'(a), int'(b), int'(k), 3));
    end
  end

  // Present one beat and hold it until accepted (bounded).
  task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv, input logic [KW-1:0] kv);
    int n;
    bit took;
    n = 0;
    took = 1'b0;
    a = av; b = bv; k = kv; in_valid = 1'b1;
    do begin
      if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      took = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!took && n < 200);
    in_valid = 1'b0;
    if (!took) begin
      checks++; errors++;
      $display("FAIL send_timeout: beat not accepted within %0d cycles", n);
    end else begin
      acc_total++;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    while ((q.size() != 0 || qc.size() != 0) && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (q.size() != 0 || qc.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: %0d/%0d beats still expected", q.size(), qc.size());
    end
  endtask

  // One beat into an empty pipe with literal expectations and latency check.
  task automatic directed(input logic [W-1:0] av, input logic [W-1:0] bv, input logic [KW-1:0] kv,
                          input logic [W-1:0] es,  input logic ec,  input logic [KW-1:0] ek,
                          input logic [W-1:0] esc, input logic ecc, input logic [KW-1:0] ekc);
    out_ready = 1'b1;
    send(av, bv, kv);
    chk("lat_cycle1_out_valid", out_valid, 1'b0);
    @(posedge clk);
    #1;
    chk("lat_cycle2_out_valid", out_valid, 1'b1);
    chk("dir_sum", sum, es);
    chk("dir_cout", cout, ec);
    chk("dir_k_used", k_used, ek);
    chk("dir_out_valid_c", out_valid_c, 1'b1);
    chk("dir_sum_c", sum_c, esc);
    chk("dir_cout_c", cout_c, ecc);
    chk("dir_k_used_c", k_used_c, ekc);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    exp_t m;
    logic [LOA_MAXW:0] r;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; k = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_sum", sum, 8'h00);
    chk("rst_cout", cout, 1'b0);
    chk("rst_k_used", k_used, 4'd0);
    chk("rst_approx_cnt", cnt, 16'h0000);
    chk("rst_out_valid_c", out_valid_c, 1'b0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1'b1);

    // Pin the bench model and the package reference to hand-computed values.
    m = model(32'h17, 32'h2B, 4, 8);
    chk("model_17_2B_k4", {m.c, m.s}, 9'h03F);
    m = model(32'h0F, 32'h01, 6, 3);
    chk("model_clamp", {m.k, m.c, m.s}, {4'd3, 9'h00F});
    r = loa_ref(64'hFF, 64'h01, 0, 8);
    chk("loa_ref_exact", 32'(r[8:0]), 9'h100);
    r = loa_ref(64'h81, 64'h80, 8, 8);
    chk("loa_ref_full_or", 32'(r[8:0]), 9'h181);

    @(posedge clk);
    #1;
    //        a      b      k     sum   c     k   | sum_c c   k_c
    directed(8'hFF, 8'h01, 4'd0, 8'h00, 1'b1, 4'd0, 8'h00, 1'b1, 4'd0);
    directed(8'h17, 8'h2B, 4'd4, 8'h3F, 1'b0, 4'd4, 8'h3F, 1'b0, 4'd3);
    directed(8'h17, 8'h2B, 4'd0, 8'h42, 1'b0, 4'd0, 8'h42, 1'b0, 4'd0);
    directed(8'h0F, 8'h08, 4'd4, 8'h1F, 1'b0, 4'd4, 8'h17, 1'b0, 4'd3);
    directed(8'h81, 8'h80, 4'd8, 8'h81, 1'b1, 4'd8, 8'h01, 1'b1, 4'd3);
    directed(8'h0F, 8'h01, 4'd6, 8'h0F, 1'b0, 4'd6, 8'h0F, 1'b0, 4'd3);

    // Random operands, k over its whole field range, random gaps and stalls.
    rnd_ready = 1'b1;
    repeat (300) begin
      send(W'($urandom), W'($urandom), KW'($urandom_range(0, 15)));
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    rnd_ready = 1'b0;
    drain();

    // Backpressure: 5 beats while out_ready is held low for 4 cycles.
    out_ready = 1'b0;
    base = acc_total;
    fork
      begin
        for (int i = 0; i < 5; i++) send(W'($urandom), W'($urandom), KW'($urandom_range(0, 8)));
      end
      begin
        repeat (4) @(posedge clk);
        #2;
        chk("bp_accepts_while_stalled", acc_total - base, 2);
        chk("bp_in_ready_low", in_ready, 1'b0);
        chk("bp_out_valid_held", out_valid, 1'b1);
        out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_all_accepted", acc_total - base, 5);

    // Reset with two beats in flight.
    out_ready = 1'b1;
    send(8'h11, 8'h22, 4'd2);
    send(8'h33, 8'h44, 4'd3);
    chk("pre_rst_out_valid", out_valid, 1'b1);
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", out_valid, 1'b0);
    chk("mid_rst_approx_cnt", cnt, 16'h0000);
    chk("mid_rst_out_valid_c", out_valid_c, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    directed(8'h17, 8'h2B, 4'd4, 8'h3F, 1'b0, 4'd4, 8'h3F, 1'b0, 4'd3);
    chk("post_rst_cnt_one", cnt, 16'h0001);

    // Saturation: 65535 more approximate beats push the count past 16'hFFFF.
    out_ready = 1'b1;
    repeat (65535) send(W'($urandom), W'($urandom), 4'd1);
    drain();
    chk("cnt_saturated", cnt, 16'hFFFF);
    repeat (3) send(W'($urandom), W'($urandom), 4'd2);
    drain();
    @(posedge clk);
    #1;
    chk("cnt_stays_saturated", cnt, 16'hFFFF);
    chk("cnt_c_stays_saturated", cnt_c, 16'hFFFF);
    chk("no_beats_left", q.size() + qc.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
